// File: rtl/instr_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_encoder : streaming RV32I encoder and instruction-memory loader
// Revision      : 1.0
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cls,
  input  logic [2:0]        in_funct3,
  input  logic              in_f7b,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic              wrapped
);

  localparam logic [3:0] CLS_ALUREG = 4'd0;
  localparam logic [3:0] CLS_ALUIMM = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JAL    = 4'd5;
  localparam logic [3:0] CLS_JALR   = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;
  localparam logic [3:0] CLS_SYSTEM = 4'd9;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic              s1_v;
  logic [3:0]        s1_cls;
  logic [2:0]        s1_f3;
  logic              s1_f7b;
  logic [4:0]        s1_rd;
  logic [4:0]        s1_rs1;
  logic [4:0]        s1_rs2;
  logic [31:0]       s1_imm;
  logic [ADDR_W-1:0] next_addr;

  logic        s2_free;
  logic        s1_load;
  logic        move;
  logic        reject;
  logic        enc_ok;
  logic [31:0] enc_word;
  logic        i_fit;
  logic        b_fit;
  logic        j_fit;
  logic [6:0]  f7;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_v || s2_free;
  assign s1_load  = in_valid && in_ready;
  assign move     = s1_v && enc_ok && s2_free;
  assign reject   = s1_v && !enc_ok;

  // Immediate range checks: the dropped upper bits must all equal the sign bit.
  assign i_fit = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign b_fit = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
  assign j_fit = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];
  assign f7    = {1'b0, s1_f7b, 5'b00000};

  always_comb begin
    enc_word = 32'h0000_0000;
    enc_ok   = 1'b1;
    case (s1_cls)
      CLS_ALUREG: begin
        enc_word = {f7, s1_rs2, s1_rs1, s1_f3, s1_rd, OP_ALUREG};
        enc_ok   = !s1_f7b || (s1_f3 == 3'b000) || (s1_f3 == 3'b101);
      end
      CLS_ALUIMM: begin
        if ((s1_f3 == 3'b001) || (s1_f3 == 3'b101)) begin
          enc_word = {f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, OP_ALUIMM};
          enc_ok   = !(|s1_imm[31:5]) && !((s1_f3 == 3'b001) && s1_f7b);
        end else begin
          enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, OP_ALUIMM};
          enc_ok   = i_fit;
        end
      end
      CLS_LOAD: begin
        enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, OP_LOAD};
        enc_ok   = i_fit && (s1_f3 != 3'b011) && (s1_f3 != 3'b110) && (s1_f3 != 3'b111);
      end
      CLS_STORE: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], OP_STORE};
        enc_ok   = i_fit && !s1_f3[2] && (s1_f3 != 3'b011);
      end
      CLS_BRANCH: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                    s1_imm[4:1], s1_imm[11], OP_BRANCH};
        enc_ok   = b_fit && (s1_f3[2:1] != 2'b01);
      end
      CLS_JAL: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, OP_JAL};
        enc_ok   = j_fit;
      end
      CLS_JALR: begin
        enc_word = {s1_imm[11:0], s1_rs1, 3'b000, s1_rd, OP_JALR};
        enc_ok   = i_fit && (s1_f3 == 3'b000);
      end
      CLS_LUI: begin
        enc_word = {s1_imm[31:12], s1_rd, OP_LUI};
        enc_ok   = !(|s1_imm[11:0]);
      end
      CLS_AUIPC: begin
        enc_word = {s1_imm[31:12], s1_rd, OP_AUIPC};
        enc_ok   = !(|s1_imm[11:0]);
      end
      CLS_SYSTEM: enc_word = 32'h0000_0073;
      default:    enc_ok   = 1'b0;
    endcase
  end

  // S1: a rejected request leaves at the next edge even while S2 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_cls <= 4'd0;
      s1_f3  <= 3'd0;
      s1_f7b <= 1'b0;
      s1_rd  <= 5'd0;
      s1_rs1 <= 5'd0;
      s1_rs2 <= 5'd0;
      s1_imm <= 32'd0;
    end else if (s1_load) begin
      s1_v   <= 1'b1;
      s1_cls <= in_cls;
      s1_f3  <= in_funct3;
      s1_f7b <= in_f7b;
      s1_rd  <= in_rd;
      s1_rs1 <= in_rs1;
      s1_rs2 <= in_rs2;
      s1_imm <= in_imm;
    end else if (move || reject) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_addr  <= '0;
      next_addr <= '0;
      err       <= 1'b0;
      err_cnt   <= 8'd0;
      wrapped   <= 1'b0;
    end else begin
      if (move) begin
        out_valid <= 1'b1;
        out_instr <= enc_word;
        out_addr  <= next_addr;
        next_addr <= next_addr + 1'b1;
        if (&next_addr) begin
          wrapped <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (reject) begin
        err <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// tb_instr_encoder : directed self-checking bench for instr_encoder
// Revision         : 1.0
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        sel2 = 1'b0;
  logic [3:0]  in_cls = 4'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic        in_f7b = 1'b0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [31:0] in_imm = 32'd0;
  logic        hold_ready = 1'b1;
  logic        rand_en = 1'b0;
  logic        rand_bit = 1'b1;
  logic        out_ready;

  logic        in_ready, out_valid, err, wrapped;
  logic [31:0] out_instr;
  logic [9:0]  out_addr;
  logic [7:0]  err_cnt;

  logic        in_ready2, out_valid2, err2, wrapped2;
  logic [31:0] out_instr2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_cnt2;

  int checks = 0;
  int errors = 0;

  logic        mon_en = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] held_instr = 32'd0;
  logic [9:0]  held_addr = 10'd0;
  logic [31:0] got_i [$];
  logic [9:0]  got_a [$];

  assign out_ready = rand_en ? rand_bit : hold_ready;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel2), .in_ready(in_ready),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b(in_f7b),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt), .wrapped(wrapped)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel2), .in_ready(in_ready2),
    .in_cls(in_cls), .in_funct3(in_funct3), .in_f7b(in_f7b),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_addr(out_addr2),
    .err(err2), .err_cnt(err_cnt2), .wrapped(wrapped2)
  );

  // Random sink stalls change just after the clock edge so ready is settled at the falling edge.
  always @(posedge clk) begin
    #2;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_instr !== held_instr || out_addr !== held_addr) begin
          errors++;
          $display("FAIL stall_hold: valid=%b instr=%h addr=%0d, required valid=1 instr=%h addr=%0d",
                   out_valid, out_instr, out_addr, held_instr, held_addr);
        end
      end
      stalled    = out_valid && !out_ready;
      held_instr = out_instr;
      held_addr  = out_addr;
      if (out_valid && out_ready) begin
        got_i.push_back(out_instr);
        got_a.push_back(out_addr);
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic send(input logic [3:0] cls, input logic [2:0] f3, input logic f7b,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    in_cls = cls; in_funct3 = f3; in_f7b = f7b;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    while (!(sel2 ? in_ready2 : in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hold_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_out: valid=%b instr=%h addr=%0d, required 0/0/0", out_valid, out_instr, out_addr);
    end
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0 || wrapped !== 1'b0 || wrapped2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: err=%b cnt=%0d wrapped=%b/%b, required 0/0/0/0", err, err_cnt, wrapped, wrapped2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    end
  endtask

  task automatic test_encode();
    logic [3:0]  t_cls [7] = '{4'd0, 4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd9};
    logic [2:0]  t_f3  [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
    logic        t_f7b [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  t_rd  [7] = '{5'd3, 5'd3, 5'd1, 5'd0, 5'd1, 5'd5, 5'd5};
    logic [4:0]  t_rs1 [7] = '{5'd1, 5'd1, 5'd0, 5'd1, 5'd7, 5'd3, 5'd4};
    logic [4:0]  t_rs2 [7] = '{5'd2, 5'd2, 5'd0, 5'd2, 5'd9, 5'd6, 5'd8};
    logic [31:0] t_imm [7] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'd8,
                               32'h1234_5000, 32'd123};
    logic [31:0] t_exp [7] = '{32'h0020_81B3, 32'h4020_81B3, 32'hFFF0_0093, 32'hFE20_8EE3,
                               32'h0080_00EF, 32'h1234_52B7, 32'h0000_0073};
    for (int i = 0; i < 7; i++) begin
      send(t_cls[i], t_f3[i], t_f7b[i], t_rd[i], t_rs1[i], t_rs2[i], t_imm[i]);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL encode_latency[%0d]: out_valid=%b one edge after accept, required 0", i, out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== t_exp[i] || out_addr !== 10'(i)) begin
        errors++;
        $display("FAIL encode[%0d]: valid=%b instr=%h addr=%0d, required 1 %h %0d",
                 i, out_valid, out_instr, out_addr, t_exp[i], i);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  t_cls [5] = '{4'd4, 4'd2, 4'd12, 4'd1, 4'd7};
    logic [2:0]  t_f3  [5] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd0};
    logic [31:0] t_imm [5] = '{32'd3, 32'd0, 32'd0, 32'd2048, 32'h0000_1001};
    for (int i = 0; i < 5; i++) begin
      send(t_cls[i], t_f3[i], 1'b0, 5'd1, 5'd2, 5'd3, t_imm[i]);
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || err !== 1'b1 || err_cnt !== 8'(i + 1)) begin
        errors++;
        $display("FAIL illegal[%0d]: valid=%b err=%b cnt=%0d, required 0 1 %0d", i, out_valid, err, err_cnt, i + 1);
      end
    end
    send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd5);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0050_0113 || out_addr !== 10'd7 || err_cnt !== 8'd5) begin
      errors++;
      $display("FAIL illegal_next: valid=%b instr=%h addr=%0d cnt=%0d, required 1 00500113 7 5",
               out_valid, out_instr, out_addr, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp_i;
    do_reset();
    got_i.delete();
    got_a.delete();
    mon_en  = 1'b1;
    rand_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      send(4'd1, 3'd0, 1'b0, 5'(k), 5'd0, 5'd0, 32'(k + 1));
    end
    n = 0;
    while (got_i.size() < 20 && n < 400) begin
      @(negedge clk);
      n++;
    end
    rand_en = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (got_i.size() != 20) begin
      errors++;
      $display("FAIL stream_count: got %0d words, required 20", got_i.size());
    end
    for (int k = 0; k < 20 && k < got_i.size(); k++) begin
      exp_i = {12'(k + 1), 5'd0, 3'd0, 5'(k), 7'h13};
      checks++;
      if (got_i[k] !== exp_i || got_a[k] !== 10'(k)) begin
        errors++;
        $display("FAIL stream[%0d]: instr=%h addr=%0d, required %h %0d", k, got_i[k], got_a[k], exp_i, k);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sel2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i));
      @(posedge clk);
      #1;
      checks++;
      if (out_valid2 !== 1'b1 || out_addr2 !== 2'(i) || out_instr2 !== {12'(i), 20'h00093}) begin
        errors++;
        $display("FAIL wrap_addr[%0d]: valid=%b addr=%0d instr=%h, required 1 %0d %h",
                 i, out_valid2, out_addr2, out_instr2, i % 4, {12'(i), 20'h00093});
      end
      if (i == 0) begin
        checks++;
        if (wrapped2 !== 1'b0) begin
          errors++;
          $display("FAIL wrap_early: wrapped=%b, required 0", wrapped2);
        end
      end
    end
    checks++;
    if (wrapped2 !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flag: wrapped=%b main_valid=%b, required 1 0", wrapped2, out_valid);
    end
    sel2 = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    hold_ready = 1'b0;
    send(4'd12, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    send(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
    send(4'd1, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h0010_0093 ||
        out_addr !== 10'd0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL full_stall: ready=%b valid=%b instr=%h addr=%0d cnt=%0d, required 0 1 00100093 0 1",
               in_ready, out_valid, out_instr, out_addr, err_cnt);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== 10'd0 ||
        err !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset: valid=%b instr=%h addr=%0d err=%b cnt=%0d ready=%b, required 0 0 0 0 0 1",
               out_valid, out_instr, out_addr, err, err_cnt, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    hold_ready = 1'b1;
    send(4'd1, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3);
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0030_0193 || out_addr !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_word: valid=%b instr=%h addr=%0d, required 1 00300193 0",
               out_valid, out_instr, out_addr);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
